// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer and its testbench.
package alu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SHOW    = 3'd4
  } state_t;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int FLG_N = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_P = 0;

  // Display phase code; CAPTURE and SHOW share the same code.
  function automatic logic [1:0] state_code(input state_t s);
    case (s)
      ST_WAIT_A:  return 2'd0;
      ST_WAIT_B:  return 2'd1;
      ST_WAIT_OP: return 2'd2;
      default:    return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/rise_edge_pulse.sv
// One-cycle pulse on each 0->1 transition of a debounced level input.
module rise_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic hist_q, hist_d;
  logic armed_q, armed_d;

  always_comb begin
    hist_d  = btn;
    armed_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      armed_q <= armed_d;
    end
  end

  // armed_q blocks a spurious pulse when the button is already held as reset releases.
  assign pulse = btn & ~hist_q & armed_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Collects operand A, operand B and opcode from button entries, drives an external
// ALU and captures its result and flags.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int M = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] data_in,
  input  logic         enter,
  input  logic         undo,
  output logic [M-1:0] alu_a,
  output logic [M-1:0] alu_b,
  output logic [1:0]   alu_opcode,
  input  logic [M-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic [M-1:0] result_out,
  output logic [4:0]   flags_out,
  output logic         valid,
  output logic [1:0]   state_out
);

  logic enter_p, undo_p;
  logic ent_go, und_go;

  state_t      state_q, state_d;
  logic [M-1:0] alu_a_q, alu_a_d;
  logic [M-1:0] alu_b_q, alu_b_d;
  logic [1:0]   alu_opcode_q, alu_opcode_d;
  logic [M-1:0] result_out_q, result_out_d;
  logic [4:0]   flags_out_q, flags_out_d;
  logic         valid_q, valid_d;

  rise_edge_pulse u_enter_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (enter),
    .pulse (enter_p)
  );

  rise_edge_pulse u_undo_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (undo),
    .pulse (undo_p)
  );

  // Simultaneous enter and undo cancel each other.
  assign ent_go = enter_p & ~undo_p;
  assign und_go = undo_p & ~enter_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_WAIT_A;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= OP_SUB;
      result_out_q <= '0;
      flags_out_q  <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      result_out_q <= result_out_d;
      flags_out_q  <= flags_out_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_A: begin
        if (ent_go) state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (ent_go)      state_d = ST_WAIT_OP;
        else if (und_go) state_d = ST_WAIT_A;
      end
      ST_WAIT_OP: begin
        if (ent_go)      state_d = ST_CAPTURE;
        else if (und_go) state_d = ST_WAIT_B;
      end
      ST_CAPTURE: state_d = ST_SHOW;
      ST_SHOW: begin
        if (ent_go)      state_d = ST_WAIT_A;
        else if (und_go) state_d = ST_WAIT_OP;
      end
      default: state_d = ST_WAIT_A;
    endcase
  end

  always_comb begin
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    result_out_d = result_out_q;
    flags_out_d  = flags_out_q;
    valid_d      = valid_q;
    case (state_q)
      ST_WAIT_A:  if (ent_go) alu_a_d = data_in;
      ST_WAIT_B:  if (ent_go) alu_b_d = data_in;
      ST_WAIT_OP: if (ent_go) alu_opcode_d = data_in[1:0];
      ST_CAPTURE: begin
        result_out_d = alu_result;
        flags_out_d  = alu_flags;
        valid_d      = 1'b1;
      end
      ST_SHOW:    if (ent_go || und_go) valid_d = 1'b0;
      default:    valid_d = 1'b0;
    endcase
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign result_out = result_out_q;
  assign flags_out  = flags_out_q;
  assign valid      = valid_q;
  assign state_out  = state_code(state_q);

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter M, default 7, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data_in  input  M  operand/opcode entry value (switches); opcode taken from data_in[1:0].
REQ-005 SHALL have port enter  input  1  debounced level button; each 0->1 transition is one entry event.
REQ-006 SHALL have port undo  input  1  debounced level button; each 0->1 transition steps back one entry.
REQ-007 SHALL have port alu_a  output  M  registered operand A driven to the external combinational ALU.
REQ-008 SHALL have port alu_b  output  M  registered operand B driven to the ALU.
REQ-009 SHALL have port alu_opcode  output  2  registered opcode: 00 sub, 01 add, 10 OR, 11 AND.
REQ-010 SHALL have port alu_result  input  M  combinational result returned by the ALU.
REQ-011 SHALL have port alu_flags  input  5  ALU flags {N,Z,C,V,P}, bit 4 down to bit 0.
REQ-012 SHALL have port result_out  output  M  captured result, held until next capture or reset.
REQ-013 SHALL have port flags_out  output  5  captured flags, same bit order as alu_flags.
REQ-014 SHALL have port valid  output  1  high only while result_out/flags_out belong to the current A/B/opcode.
REQ-015 SHALL have port state_out  output  2  current phase code for display: 0 WAIT_A, 1 WAIT_B, 2 WAIT_OP, 3 CAPTURE/SHOW.

Function
REQ-016 SHALL implement states WAIT_A, WAIT_B, WAIT_OP, CAPTURE, SHOW.
REQ-017 SHALL derive enter_p and undo_p as one-cycle pulses on the 0->1 transition of enter/undo; a held button SHALL produce exactly one pulse.
REQ-018 SHALL, in WAIT_A on enter_p, load alu_a <= data_in and go to WAIT_B.
REQ-019 SHALL, in WAIT_B on enter_p, load alu_b <= data_in and go to WAIT_OP.
REQ-020 SHALL, in WAIT_OP on enter_p, load alu_opcode <= data_in[1:0] and go to CAPTURE.
REQ-021 SHALL, in CAPTURE, unconditionally register result_out <= alu_result, flags_out <= alu_flags, set valid=1, and go to SHOW next cycle (capture latency: 1 cycle after opcode load, 2 cycles after enter_p).
REQ-022 SHALL, in SHOW on enter_p, clear valid and go to WAIT_A; result_out/flags_out keep their values; alu_a/alu_b/alu_opcode unchanged until reloaded.
REQ-023 SHALL, on undo_p: WAIT_B->WAIT_A, WAIT_OP->WAIT_B, SHOW->WAIT_OP with valid cleared; WAIT_A and CAPTURE SHALL ignore undo_p.
REQ-024 SHALL ignore both pulses when enter_p and undo_p occur in the same cycle.
REQ-025 SHALL ignore pulses arriving in CAPTURE (no queuing).
REQ-026 SHALL pass operands and opcode unmodified; no arithmetic, truncation or sign handling inside this block.
REQ-027 SHALL drive state_out combinationally from state; CAPTURE and SHOW both encode 3.

Reset
REQ-028 SHALL, on reset high at a clock edge, force state WAIT_A, alu_a=0, alu_b=0, alu_opcode=00, result_out=0, flags_out=0, valid=0, edge-detector history=0.
REQ-029 SHALL abandon any partial entry when reset asserts mid-sequence; reset SHALL dominate enter/undo in the same cycle.
REQ-030 SHALL NOT generate an enter_p/undo_p in the first cycle after reset if the button is already high.

Structure
REQ-031 SHALL place the state enum, opcode constants (OP_SUB, OP_ADD, OP_OR, OP_AND) and flag bit indices (FLG_N=4, FLG_Z=3, FLG_C=2, FLG_V=1, FLG_P=0) in shared package alu_pkg.
REQ-032 SHALL use one sub-module, rise_edge_pulse, instantiated twice (enter, undo).

Verification (M=7; bench ALU stub: alu_result = opcode-selected A-B / A+B / A|B / A&B, mod 2^7)
REQ-033 SHALL cover: enter 7'd20, 7'd5, op 01 -> alu_a=20, alu_b=5, result_out=25 and valid=1 exactly two cycles after the third enter_p.
REQ-034 SHALL cover: enter 7'd100, 7'd50, op 01 -> result_out=22 (wrap), flags_out equals stub flags sampled in CAPTURE.
REQ-035 SHALL cover: enter held high 20 cycles in WAIT_A -> single transition to WAIT_B only.
REQ-036 SHALL cover: A=3, B=9, undo in WAIT_OP, re-enter B=4, op 00 -> result_out=7'd127 (3-4 wrapped), valid=1.
REQ-037 SHALL cover: reset asserted in WAIT_OP -> next cycle state_out=0, all outputs 0, valid=0.
REQ-038 SHALL cover: enter and undo rising in the same cycle in WAIT_B -> state stays WAIT_B, alu_b unchanged.
